exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Run-control sequencer for the 8-bit single-cycle CPU datapath.
- Generates a one-cycle instruction-commit enable (cpu_en) for the datapath's PC, register file and data memory. This replaces free-running divided-clock execution with run, single-step, halt and breakpoint control.
- Sits between board push-buttons (already synchronised to single-cycle pulses) and the datapath. It observes the datapath's PC and instruction outputs.

Parameters:
- DIV, 4, number of CLK cycles between cpu_en pulses in RUN; legal range 1..2^PRESC_W.
- PRESC_W, 24, prescaler counter width.
- HALT_INSTR, 8'hFF, instruction encoding that stops execution (enters DONE) instead of committing.
- ICNT_W, 16, retired-instruction counter width.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- run  in  1  single-cycle pulse: start or continue execution.
- step  in  1  single-cycle pulse: execute exactly one instruction.
- halt  in  1  single-cycle pulse: stop and return to IDLE.
- bp_set  in  1  pulse: load bp_addr into the breakpoint register and arm it.
- bp_addr  in  8  breakpoint PC value.
- PC  in  8  current datapath PC.
- instruction  in  8  instruction at the current PC.
- cpu_en  out  1  registered commit enable; the datapath advances one instruction on a CLK edge where cpu_en=1.
- state  out  3  FSM state: IDLE=0, RUN=1, STEP=2, BREAK=3, DONE=4.
- bp_hit  out  1  high while in BREAK.
- icount  out  ICNT_W  retired-instruction count.

Behaviour:
- Reset (async, any state, including mid-prescale or mid-step):
  - state=IDLE, cpu_en=0, icount=0, prescaler=0, bp_valid=0, bp_reg=0, resume_skip=0.
  - All outputs are registered and take effect immediately on RESET assertion.
- Command priority when pulses coincide: halt > step > run. bp_set is independent, accepted in every state, and takes effect the next cycle.
- Pre-issue check, evaluated in the cycle a pulse would be issued, in this order:
  - instruction==HALT_INSTR: go to DONE and issue no pulse.
  - else bp_valid and PC==bp_reg and resume_skip==0: go to BREAK and issue no pulse.
  - else issue the pulse.
- IDLE: run -> RUN with prescaler=0; step -> STEP; halt ignored. cpu_en=0.
- RUN:
  - Prescaler counts 0..DIV-1.
  - At count DIV-1 the pre-issue check is applied; if it passes, cpu_en=1 next cycle for exactly one cycle. The prescaler wraps to 0 either way.
  - DIV=1 gives cpu_en high every cycle until a stop condition.
  - halt -> IDLE, prescaler cleared. A pulse already registered still completes; no new pulse is issued.
- STEP:
  - The pre-issue check is applied in the entry cycle.
  - If it passes, cpu_en=1 on the following cycle, then return to IDLE.
  - step/run pulses arriving while in STEP are ignored.
- BREAK:
  - run -> RUN with resume_skip=1; step -> STEP with resume_skip=1; halt -> IDLE.
  - resume_skip clears after the next issued pulse, so the breakpoint instruction executes once on resume.
- DONE:
  - Only halt (-> IDLE) or RESET exit.
  - Re-running while the HALT_INSTR is still at PC re-enters DONE without a pulse.
- icount:
  - Increments on every CLK edge with cpu_en=1.
  - Saturates at all-ones (no wrap).
  - Unaffected by halt; cleared only by RESET.
- Exactly one cpu_en pulse per issue. cpu_en is never high for two consecutive cycles unless DIV=1 in RUN.

Optional Feature:
- Macro: EXEC_SEQ_BREAKPOINT_EN.
- Defined: breakpoint register, compare logic, resume_skip and the BREAK state are implemented as described.
- Undefined:
  - bp_set and bp_addr are ignored and BREAK is unreachable.
  - bp_hit is tied to 0.
  - The pre-issue check tests HALT_INSTR only.
  - The port list is unchanged.

Decomposition:
- Package exec_seq_pkg holds:
  - state encoding constants (S_IDLE..S_DONE, 3 bits);
  - the default HALT_INSTR constant;
  - width constants (PC_W=8, INSTR_W=8).
- One sub-module, en_prescaler:
  - parameters DIV and PRESC_W;
  - inputs: clear, enable;
  - output: a single-cycle tick at count DIV-1.
- The FSM, breakpoint logic and counter stay in exec_sequencer.

Test Plan:
- Basic run: reset, DIV=4, instruction=8'h12, pulse run -> cpu_en high for 1 cycle every 4 cycles; icount=5 after 20 cycles of RUN; state=1.
- Single step: from IDLE pulse step -> exactly one cpu_en pulse 2 cycles later; state returns to 0; icount=1. A second step pulse during STEP produces no extra pulse.
- Breakpoint hit and resume (macro defined): bp_set with bp_addr=8'h05, run, drive PC=8'h05 -> state=3, bp_hit=1, no pulse. Pulse run -> one pulse issued with PC still 8'h05, then normal RUN.
- Halt instruction: during RUN drive instruction=8'hFF -> state=4, cpu_en stays 0, icount frozen. Halt pulse -> state=0.
- Simultaneous and reset: run+halt in the same cycle from IDLE -> stays IDLE. Assert RESET mid-prescale in RUN -> cpu_en=0, icount=0, state=0 immediately, with no clock edge needed.
- Saturation: ICNT_W=4, DIV=1, run 20 cycles -> icount=4'hF held.

Source files
------------

// File: rtl/exec_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | exec_seq_pkg : shared encodings and widths for the run-control sequencer |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package exec_seq_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 8;

  localparam logic [INSTR_W-1:0] C_HALT_INSTR_DEF = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_BREAK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/exec_sequencer_en_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | en_prescaler : free-running 0..DIV-1 counter with a tick at DIV-1        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module en_prescaler #(
  parameter int DIV     = 4,
  parameter int PRESC_W = 24
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  if ((DIV < 1) || (DIV > (2 ** PRESC_W))) begin : g_bad_div
    $error("en_prescaler: DIV out of range 1..2^PRESC_W");
  end

  localparam logic [PRESC_W-1:0] C_LAST = PRESC_W'(DIV - 1);

  logic [PRESC_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      if (cnt_q == C_LAST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign tick_o = enable_i && !clear_i && (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/exec_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | exec_sequencer : run/step/halt/breakpoint commit-enable sequencer        |
// | Optional breakpoint logic: define EXEC_SEQ_BREAKPOINT_EN. Rev 1.0        |
// +--------------------------------------------------------------------------+
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int                  DIV        = 4,
  parameter int                  PRESC_W    = 24,
  parameter logic [INSTR_W-1:0]  HALT_INSTR = C_HALT_INSTR_DEF,
  parameter int                  ICNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              run,
  input  logic              step,
  input  logic              halt,
  input  logic              bp_set,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [PC_W-1:0]   PC,
  input  logic [INSTR_W-1:0] instruction,
  output logic              cpu_en,
  output logic [2:0]        state,
  output logic              bp_hit,
  output logic [ICNT_W-1:0] icount
);

  state_e            state_q;
  logic              cpu_en_q;
  logic [ICNT_W-1:0] icount_q;

  logic tick_w;
  logic is_halt_w;
  logic bp_stop_w;
  logic check_w;
  logic issue_w;

  en_prescaler #(
    .DIV     (DIV),
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .clear_i  (state_q != S_RUN),
    .enable_i (state_q == S_RUN),
    .tick_o   (tick_w)
  );

  assign is_halt_w = (instruction == HALT_INSTR);

`ifdef EXEC_SEQ_BREAKPOINT_EN
  logic            bp_valid_q;
  logic [PC_W-1:0] bp_reg_q;
  logic            resume_skip_q;
  logic            resume_w;

  assign resume_w  = (state_q == S_BREAK) && !halt && (step || run);
  assign bp_stop_w = bp_valid_q && (PC == bp_reg_q) && !resume_skip_q;
  assign bp_hit    = (state_q == S_BREAK);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bp_valid_q    <= 1'b0;
      bp_reg_q      <= '0;
      resume_skip_q <= 1'b0;
    end else begin
      if (bp_set) begin
        bp_valid_q <= 1'b1;
        bp_reg_q   <= bp_addr;
      end
      // Skip is held only until the breakpoint instruction itself commits.
      if (resume_w) begin
        resume_skip_q <= 1'b1;
      end else if (issue_w) begin
        resume_skip_q <= 1'b0;
      end
    end
  end
`else
  logic unused_bp_w;
  assign unused_bp_w = ^{bp_set, bp_addr, PC};
  assign bp_stop_w   = 1'b0;
  assign bp_hit      = 1'b0;
`endif

  // A pulse is considered on the prescaler tick in RUN, or on the single cycle spent in STEP.
  assign check_w = !halt && (((state_q == S_RUN) && tick_w) || (state_q == S_STEP));
  assign issue_w = check_w && !is_halt_w && !bp_stop_w;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cpu_en_q <= 1'b0;
    end else begin
      cpu_en_q <= issue_w;
      case (state_q)
        S_IDLE: begin
          if (!halt && step) begin
            state_q <= S_STEP;
          end else if (!halt && run) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (halt) begin
            state_q <= S_IDLE;
          end else if (check_w && is_halt_w) begin
            state_q <= S_DONE;
          end else if (check_w && bp_stop_w) begin
            state_q <= S_BREAK;
          end
        end
        S_STEP: begin
          if (halt) begin
            state_q <= S_IDLE;
          end else if (is_halt_w) begin
            state_q <= S_DONE;
          end else if (bp_stop_w) begin
            state_q <= S_BREAK;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_BREAK: begin
          if (halt) begin
            state_q <= S_IDLE;
          end else if (step) begin
            state_q <= S_STEP;
          end else if (run) begin
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          if (halt) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      icount_q <= '0;
    end else if (cpu_en_q && (icount_q != '1)) begin
      icount_q <= icount_q + 1'b1;
    end
  end

  assign cpu_en = cpu_en_q;
  assign state  = state_q;
  assign icount = icount_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_exec_sequencer : directed table-driven bench for exec_sequencer       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_exec_sequencer;

  logic        CLK;
  logic        RESET;
  logic        run, step, halt, bp_set;
  logic [7:0]  bp_addr, PC, instruction;
  logic        cpu_en;
  logic [2:0]  state;
  logic        bp_hit;
  logic [15:0] icount;

  logic        run2;
  logic        zero_b;
  logic [7:0]  zero_8, instr2;
  logic        cpu_en2;
  logic [2:0]  state2;
  logic        bp_hit2;
  logic [3:0]  icount2;

  int checks = 0;
  int errors = 0;

  exec_sequencer #(.DIV(4), .PRESC_W(24), .HALT_INSTR(8'hFF), .ICNT_W(16)) u_dut (
    .CLK(CLK), .RESET(RESET), .run(run), .step(step), .halt(halt),
    .bp_set(bp_set), .bp_addr(bp_addr), .PC(PC), .instruction(instruction),
    .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit), .icount(icount)
  );

  exec_sequencer #(.DIV(1), .PRESC_W(24), .HALT_INSTR(8'hFF), .ICNT_W(4)) u_sat (
    .CLK(CLK), .RESET(RESET), .run(run2), .step(zero_b), .halt(zero_b),
    .bp_set(zero_b), .bp_addr(zero_8), .PC(zero_8), .instruction(instr2),
    .cpu_en(cpu_en2), .state(state2), .bp_hit(bp_hit2), .icount(icount2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        run;
    logic        step;
    logic        halt;
    logic [7:0]  instr;
    logic [2:0]  exp_state;
    logic        exp_en;
    logic [15:0] exp_ic;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic clk1();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; run = 0; step = 0; halt = 0; bp_set = 0;
    bp_addr = 8'h00; PC = 8'h00; instruction = 8'h12;
    run2 = 0; zero_b = 0; zero_8 = 8'h00; instr2 = 8'h12;

    // Each row: inputs held across one edge, then outputs expected after it.
    vt[0]  = '{1'b0, 1'b1, 1'b0, 8'h12, 3'd2, 1'b0, 16'd0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 8'h12, 3'd0, 1'b1, 16'd0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 8'h12, 3'd0, 1'b0, 16'd1};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 8'h12, 3'd0, 1'b0, 16'd1};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 8'h12, 3'd0, 1'b0, 16'd1};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 8'h12, 3'd2, 1'b0, 16'd1};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 8'h12, 3'd0, 1'b1, 16'd1};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 8'h12, 3'd0, 1'b0, 16'd2};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 3'd2, 1'b0, 16'd2};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 8'hFF, 3'd4, 1'b0, 16'd2};
    vt[10] = '{1'b1, 1'b0, 1'b0, 8'hFF, 3'd4, 1'b0, 16'd2};
    vt[11] = '{1'b0, 1'b0, 1'b1, 8'hFF, 3'd0, 1'b0, 16'd2};
    vt[12] = '{1'b1, 1'b0, 1'b0, 8'hFF, 3'd1, 1'b0, 16'd2};
    vt[13] = '{1'b0, 1'b0, 1'b0, 8'hFF, 3'd1, 1'b0, 16'd2};
    vt[14] = '{1'b0, 1'b0, 1'b0, 8'hFF, 3'd1, 1'b0, 16'd2};
    vt[15] = '{1'b0, 1'b0, 1'b0, 8'hFF, 3'd1, 1'b0, 16'd2};
    vt[16] = '{1'b0, 1'b0, 1'b0, 8'hFF, 3'd4, 1'b0, 16'd2};
    vt[17] = '{1'b0, 1'b0, 1'b1, 8'hFF, 3'd0, 1'b0, 16'd2};

    #2;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_cpu_en", 32'(cpu_en), 32'd0);
    chk("reset_icount", 32'(icount), 32'd0);
    chk("reset_bp_hit", 32'(bp_hit), 32'd0);
    chk("reset_sat_icount", 32'(icount2), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run = vt[i].run; step = vt[i].step; halt = vt[i].halt;
      instruction = vt[i].instr;
      clk1();
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vt[i].exp_state));
      chk($sformatf("vec%0d_cpu_en", i), 32'(cpu_en), 32'(vt[i].exp_en));
      chk($sformatf("vec%0d_icount", i), 32'(icount), 32'(vt[i].exp_ic));
    end
    run = 0; step = 0; halt = 0; instruction = 8'h12;

    // Basic RUN: first pulse 5 edges after run is latched, then every 4.
    do_reset();
    run = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      clk1();
      run = 1'b0;
      chk($sformatf("run_en_s%0d", n), 32'(cpu_en), 32'((n >= 5) && (((n - 5) % 4) == 0)));
    end
    chk("run_state", 32'(state), 32'd1);
    chk("run_icount", 32'(icount), 32'd5);
    halt = 1'b1;
    clk1();
    halt = 1'b0;
    chk("run_halt_state", 32'(state), 32'd0);
    clk1();
    chk("run_halt_icount", 32'(icount), 32'd5);

    // HALT_INSTR appears right after RUN starts: DONE on the first tick.
    do_reset();
    run = 1'b1;
    clk1();
    run = 1'b0;
    instruction = 8'hFF;
    for (int n = 2; n <= 8; n++) begin
      clk1();
      chk($sformatf("hi_en_s%0d", n), 32'(cpu_en), 32'd0);
      if (n == 4) chk("hi_state_pre", 32'(state), 32'd1);
    end
    chk("hi_state_done", 32'(state), 32'd4);
    chk("hi_icount", 32'(icount), 32'd0);
    halt = 1'b1;
    clk1();
    halt = 1'b0;
    instruction = 8'h12;
    chk("hi_exit_state", 32'(state), 32'd0);

    // Asynchronous reset asserted between edges while cpu_en is high.
    do_reset();
    run = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      clk1();
      run = 1'b0;
    end
    chk("ar_pre_en", 32'(cpu_en), 32'd1);
    chk("ar_pre_icount", 32'(icount), 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_cpu_en", 32'(cpu_en), 32'd0);
    chk("ar_icount", 32'(icount), 32'd0);
    #2 RESET = 1'b0;

    // Breakpoint at PC 5.
    do_reset();
    bp_addr = 8'h05;
    bp_set = 1'b1;
    clk1();
    bp_set = 1'b0;
    run = 1'b1;
    clk1();
    run = 1'b0;
    PC = 8'h05;
    for (int n = 2; n <= 5; n++) clk1();
`ifdef EXEC_SEQ_BREAKPOINT_EN
    chk("bp_state", 32'(state), 32'd3);
    chk("bp_hit", 32'(bp_hit), 32'd1);
    chk("bp_en", 32'(cpu_en), 32'd0);
    run = 1'b1;
    for (int r = 1; r <= 9; r++) begin
      clk1();
      run = 1'b0;
      chk($sformatf("bp_res_en_r%0d", r), 32'(cpu_en), 32'((r == 5) || (r == 9)));
      if (r == 5) begin
        chk("bp_res_state", 32'(state), 32'd1);
        chk("bp_res_hit", 32'(bp_hit), 32'd0);
        PC = 8'h06;
      end
    end
    chk("bp_res_icount", 32'(icount), 32'd1);
`else
    chk("nobp_state", 32'(state), 32'd1);
    chk("nobp_hit", 32'(bp_hit), 32'd0);
    chk("nobp_en", 32'(cpu_en), 32'd1);
`endif
    PC = 8'h00;

    // Saturation with DIV=1 and a 4-bit counter.
    do_reset();
    run2 = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      clk1();
      run2 = 1'b0;
      if (n == 2 || n == 3) chk($sformatf("sat_en_s%0d", n), 32'(cpu_en2), 32'd1);
    end
    chk("sat_state", 32'(state2), 32'd1);
    chk("sat_icount", 32'(icount2), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
